// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
//   Shared definitions for the seven-segment readback block:
//   - segment pattern constants (a..g, bit 6 = a, bit 0 = g)
//   - BCD code reported for a blank display position
//   - tracker FSM state encoding
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    TRK_IDLE,
    TRK_SETTLE,
    TRK_LOCKED
  } tracker_state_t;

endpackage

// File: rtl/seven_seg_pattern_decoder.sv
// seven_seg_pattern_decoder
//   Combinational inverse of the BCD-to-seven-segment decoder.
//   Ports:
//     pattern  in   7  segment pattern, bit 6 = a ... bit 0 = g
//     digit    out  4  recovered BCD value (0 when the pattern is illegal)
//     legal    out  1  pattern is one of the recognised digit shapes
//   Configuration:
//     SEVEN_SEG_READER_BLANK_EN  when defined, the all-off pattern is a legal
//                                "blank" and decodes to BCD_BLANK.
module seven_seg_pattern_decoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       legal
);

  // Lookup of the ten digit shapes; anything else falls to the default arm.
  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
`ifdef SEVEN_SEG_READER_BLANK_EN
      SEG_BLANK: digit = BCD_BLANK;
`endif
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// seven_seg_reader
//   Reads back a multiplexed seven-segment bus and recovers one BCD digit per
//   display position once its pattern has been stable for STABLE_CNT samples.
//   Ports:
//     clk         in   1         rising-edge clock
//     rst         in   1         synchronous active-high reset
//     ABCDEFG     in   7         segment lines (async), bit 6 = a ... bit 0 = g
//     DIGIT_EN    in   DIGITS    one-hot digit enables (async)
//     CLEAR       in   1         clears ERROR and all VALID bits
//     BCD         out  4*DIGITS  recovered digits, digit k in [4k+3:4k]
//     VALID       out  DIGITS    digit k holds a committed legal value
//     ERROR       out  1         sticky: a stable non-digit pattern was seen
//     FRAME_DONE  out  1         pulse: last digit committed, all VALID set
//   Configuration:
//     SEVEN_SEG_READER_BLANK_EN  all-off pattern commits as blank (4'hF)
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            ABCDEFG,
  input  logic [DIGITS-1:0]     DIGIT_EN,
  input  logic                  CLEAR,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [DIGITS-1:0]     VALID,
  output logic                  ERROR,
  output logic                  FRAME_DONE
);

  localparam int              CW        = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0]   COUNT_MAX = CW'(STABLE_CNT);
  localparam logic [DIGITS-1:0] LAST_MASK = DIGITS'(1) << (DIGITS - 1);

  logic [6:0]        pat_meta, pat_sync, pat_prev;
  logic [DIGITS-1:0] en_meta, en_sync, en_prev;

  tracker_state_t    state, state_next;
  logic [CW-1:0]     count, count_next;
  logic              same, commit;

  logic [3:0]        dec_digit;
  logic              dec_legal;

  // Two-flop synchronizers plus one extra stage holding the previous
  // synchronized sample. Bits may resolve on different cycles; the stability
  // filter below absorbs that skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_meta <= '0;
      pat_sync <= '0;
      pat_prev <= '0;
      en_meta  <= '0;
      en_sync  <= '0;
      en_prev  <= '0;
    end else begin
      pat_meta <= ABCDEFG;
      pat_sync <= pat_meta;
      pat_prev <= pat_sync;
      en_meta  <= DIGIT_EN;
      en_sync  <= en_meta;
      en_prev  <= en_sync;
    end
  end

  seven_seg_pattern_decoder u_decoder (
    .pattern (pat_sync),
    .digit   (dec_digit),
    .legal   (dec_legal)
  );

  // Tracker state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TRK_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Tracker next-state. The commit fires on the edge the count reaches
  // STABLE_CNT; a held sample in LOCKED never re-commits.
  always_comb begin
    same       = (en_sync == en_prev) && (pat_sync == pat_prev);
    state_next = state;
    count_next = count;
    commit     = 1'b0;
    if (!$onehot(en_sync)) begin
      state_next = TRK_IDLE;
      count_next = '0;
    end else begin
      case (state)
        TRK_IDLE:   count_next = CW'(1);
        TRK_SETTLE: count_next = !same ? CW'(1) :
                                 (count == COUNT_MAX) ? COUNT_MAX : count + 1'b1;
        TRK_LOCKED: count_next = same ? count : CW'(1);
        default:    count_next = '0;
      endcase
      if (state == TRK_LOCKED && same) begin
        state_next = TRK_LOCKED;
      end else if (count_next == COUNT_MAX) begin
        state_next = TRK_LOCKED;
        commit     = 1'b1;
      end else begin
        state_next = TRK_SETTLE;
      end
    end
  end

  // Output registers. CLEAR is applied first so that a same-cycle commit
  // wins for its own digit and for ERROR.
  always_ff @(posedge clk) begin
    if (rst) begin
      BCD        <= '0;
      VALID      <= '0;
      ERROR      <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= commit && dec_legal && en_sync[DIGITS-1] && (&(VALID | LAST_MASK));
      if (CLEAR) begin
        VALID <= '0;
        ERROR <= 1'b0;
      end
      if (commit) begin
        for (int k = 0; k < DIGITS; k++) begin
          if (en_sync[k]) begin
            if (dec_legal) begin
              BCD[4*k +: 4] <= dec_digit;
              VALID[k]      <= 1'b1;
            end else begin
              VALID[k]      <= 1'b0;
            end
          end
        end
        if (!dec_legal) begin
          ERROR <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_reader.sv
// tb_seven_seg_reader
//   Directed and random stimulus for seven_seg_reader, checked every cycle
//   against a run-length reference model of the readback behaviour.
module tb_seven_seg_reader;

  localparam int DIGITS     = 4;
  localparam int STABLE_CNT = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [6:0]          abcdefg;
  logic [DIGITS-1:0]   digit_en;
  logic                clear;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   valid;
  logic                error;
  logic                frame_done;

  int compared   = 0;
  int mismatched = 0;
  int fd_count;

  logic [6:0] seg_table [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  logic [6:0] scan_pat [4]   = '{7'h30, 7'h79, 7'h33, 7'h5B};

  // Reference model state: raw input history, run length of identical
  // synchronized samples, and the expected outputs.
  logic [DIGITS-1:0] hist_en  [$];
  logic [6:0]        hist_pat [$];
  int                run_len;
  int                exp_digit [DIGITS];
  logic [DIGITS-1:0] exp_valid;
  logic              exp_error;
  logic              exp_frame_done;

  seven_seg_reader #(.DIGITS(DIGITS), .STABLE_CNT(STABLE_CNT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ABCDEFG    (abcdefg),
    .DIGIT_EN   (digit_en),
    .CLEAR      (clear),
    .BCD        (bcd),
    .VALID      (valid),
    .ERROR      (error),
    .FRAME_DONE (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void decodePattern(input logic [6:0] pat, output int value, output bit legal);
    value = 0;
    legal = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (seg_table[i] == pat) begin
        value = i;
        legal = 1'b1;
      end
    end
`ifdef SEVEN_SEG_READER_BLANK_EN
    if (pat == 7'h00) begin
      value = 15;
      legal = 1'b1;
    end
`endif
  endfunction

  function automatic logic [4*DIGITS-1:0] expectedBcd();
    logic [4*DIGITS-1:0] r;
    int d;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d = exp_digit[k];
      r[4*k +: 4] = d[3:0];
    end
    return r;
  endfunction

  task automatic modelReset();
    hist_en.delete();
    hist_pat.delete();
    repeat (3) begin
      hist_en.push_back('0);
      hist_pat.push_back('0);
    end
    run_len = 0;
    for (int k = 0; k < DIGITS; k++) exp_digit[k] = 0;
    exp_valid      = '0;
    exp_error      = 1'b0;
    exp_frame_done = 1'b0;
  endtask

  // One clock edge of the model: the decision at this edge uses the raw
  // inputs from two edges ago, compared against those from three edges ago.
  task automatic modelEdge(input logic [DIGITS-1:0] en, input logic [6:0] pat, input logic clr);
    logic [DIGITS-1:0] seen_en, prev_en;
    logic [6:0]        seen_pat, prev_pat;
    int                value, k;
    bit                legal, commit, others_valid;
    prev_en  = hist_en[0];
    prev_pat = hist_pat[0];
    seen_en  = hist_en[1];
    seen_pat = hist_pat[1];
    void'(hist_en.pop_front());
    void'(hist_pat.pop_front());
    hist_en.push_back(en);
    hist_pat.push_back(pat);

    if (seen_en == prev_en && seen_pat == prev_pat)
      run_len = (run_len > STABLE_CNT) ? run_len : run_len + 1;
    else
      run_len = 1;

    commit = ($countones(seen_en) == 1) && (run_len == STABLE_CNT);
    k = 0;
    for (int i = 0; i < DIGITS; i++) if (seen_en[i]) k = i;
    decodePattern(seen_pat, value, legal);

    others_valid = 1'b1;
    for (int i = 0; i < DIGITS - 1; i++) if (!exp_valid[i]) others_valid = 1'b0;
    exp_frame_done = commit && legal && (k == DIGITS - 1) && others_valid;

    if (clr) begin
      exp_valid = '0;
      exp_error = 1'b0;
    end
    if (commit) begin
      if (legal) begin
        exp_digit[k] = value;
        exp_valid[k] = 1'b1;
      end else begin
        exp_valid[k] = 1'b0;
        exp_error    = 1'b1;
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".bcd"},        32'(bcd),        32'(expectedBcd()));
    checkValue({tag, ".valid"},      32'(valid),      32'(exp_valid));
    checkValue({tag, ".error"},      32'(error),      32'(exp_error));
    checkValue({tag, ".frame_done"}, 32'(frame_done), 32'(exp_frame_done));
  endtask

  // Drive inputs, let one edge pass, advance the model, check on the falling edge.
  task automatic applyStimulus(input logic [DIGITS-1:0] en, input logic [6:0] pat,
                               input logic clr, input string tag);
    digit_en = en;
    abcdefg  = pat;
    clear    = clr;
    @(posedge clk);
    modelEdge(en, pat, clr);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic resetDut(input logic [DIGITS-1:0] en, input logic [6:0] pat);
    rst      = 1'b1;
    digit_en = en;
    abcdefg  = pat;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput("reset");
  endtask

  initial begin
    int hold, kind;
    logic [DIGITS-1:0] r_en;
    logic [6:0]        r_pat;

    $display("[TB] start");
    resetDut('0, 7'h00);
    checkValue("reset_bcd",   32'(bcd),        0);
    checkValue("reset_valid", 32'(valid),      0);
    checkValue("reset_error", 32'(error),      0);
    checkValue("reset_fd",    32'(frame_done), 0);

    // Exact commit latency of 2+STABLE_CNT edges.
    repeat (4) applyStimulus(4'b0001, 7'h6D, 1'b0, "latency");
    checkValue("latency_pre_valid", 32'(valid), 0);
    applyStimulus(4'b0001, 7'h6D, 1'b0, "latency");
    checkValue("latency_bcd0",  32'(bcd[3:0]), 2);
    checkValue("latency_valid", 32'(valid),    4'b0001);
    checkValue("latency_error", 32'(error),    0);

    // Two full scan frames; one FRAME_DONE pulse per frame.
    for (int f = 0; f < 2; f++) begin
      fd_count = 0;
      for (int d = 0; d < DIGITS; d++) begin
        repeat (8) begin
          applyStimulus(DIGITS'(1) << d, scan_pat[d], 1'b0, "scan");
          fd_count += int'(frame_done);
        end
      end
      checkValue("scan_fd_count", 32'(fd_count), 1);
    end
    checkValue("scan_bcd",   32'(bcd),   16'h5431);
    checkValue("scan_valid", 32'(valid), 4'b1111);

    // Pattern changing every cycle never settles.
    for (int i = 0; i < 12; i++)
      applyStimulus(4'b0001, (i % 2 == 0) ? 7'h7E : 7'h7F, 1'b0, "toggle");
    checkValue("toggle_bcd",   32'(bcd),   16'h5431);
    checkValue("toggle_valid", 32'(valid), 4'b1111);

    // Stable illegal pattern, then CLEAR.
    repeat (8) applyStimulus(4'b0100, 7'h01, 1'b0, "illegal");
    checkValue("illegal_valid", 32'(valid), 4'b1011);
    checkValue("illegal_error", 32'(error), 1);
    checkValue("illegal_bcd",   32'(bcd),   16'h5431);
    applyStimulus('0, 7'h00, 1'b1, "clear");
    checkValue("clear_error", 32'(error), 0);
    checkValue("clear_valid", 32'(valid), 0);

    // Multi-hot enable is ignored.
    repeat (10) applyStimulus(4'b0011, 7'h7E, 1'b0, "multihot");
    checkValue("multihot_valid", 32'(valid), 0);
    checkValue("multihot_error", 32'(error), 0);

    // All-segments-off on digit 1.
    repeat (8) applyStimulus(4'b0010, 7'h00, 1'b0, "blank");
`ifdef SEVEN_SEG_READER_BLANK_EN
    checkValue("blank_bcd1",  32'(bcd[7:4]), 4'hF);
    checkValue("blank_valid", 32'(valid),    4'b0010);
    checkValue("blank_error", 32'(error),    0);
`else
    checkValue("blank_error", 32'(error),    1);
    checkValue("blank_valid", 32'(valid),    0);
`endif

    // Reset in the middle of settling discards the partial count.
    repeat (4) applyStimulus(4'b0001, 7'h30, 1'b0, "midsettle");
    resetDut(4'b0001, 7'h30);
    repeat (4) applyStimulus(4'b0001, 7'h30, 1'b0, "postreset");
    checkValue("postreset_pre_valid", 32'(valid), 0);
    applyStimulus(4'b0001, 7'h30, 1'b0, "postreset");
    checkValue("postreset_valid", 32'(valid),    4'b0001);
    checkValue("postreset_bcd0",  32'(bcd[3:0]), 1);

    // Enable shorter than STABLE_CNT never commits.
    repeat (2) applyStimulus(4'b0100, 7'h6D, 1'b0, "short");
    repeat (6) applyStimulus('0, 7'h6D, 1'b0, "short");
    checkValue("short_valid", 32'(valid), 4'b0001);

    // Random bursts of held inputs with occasional CLEAR pulses.
    for (int s = 0; s < 150; s++) begin
      hold = int'($urandom_range(1, 8));
      kind = int'($urandom_range(0, 9));
      if (kind < 7)       r_en = DIGITS'(1) << $urandom_range(0, DIGITS - 1);
      else if (kind == 7) r_en = '0;
      else                r_en = DIGITS'($urandom());
      if ($urandom_range(0, 4) == 0) r_pat = 7'($urandom());
      else                           r_pat = seg_table[$urandom_range(0, 9)];
      for (int c = 0; c < hold; c++)
        applyStimulus(r_en, r_pat, ($urandom_range(0, 39) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seven_seg_reader.md
# seven_seg_reader

- Reads back a multiplexed seven-segment display bus (segment lines plus one-hot digit enables) and recovers one BCD digit per display position.
- It is the inverse of the BCD-to-seven-segment decoding path: it monitors the segment bus driven by our display datapath and returns the displayed value for self-check or readback.
- A digit commits only after its pattern has been stable for a programmable number of samples; non-digit patterns are flagged.

## Interface

Parameters:
- DIGITS, 4, number of multiplexed display positions (≥1).
- STABLE_CNT, 3, consecutive identical samples required to commit a digit (≥1).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ABCDEFG  input  7  segment lines, active-high; bit 6 = segment a … bit 0 = segment g. Asynchronous to clk.
- DIGIT_EN  input  DIGITS  digit enables, active-high, expected one-hot. Asynchronous to clk.
- CLEAR  input  1  synchronous pulse; clears ERROR and all VALID bits.
- BCD  output  4*DIGITS  recovered digits; digit k in bits [4k+3:4k].
- VALID  output  DIGITS  VALID[k]=1 when BCD digit k holds a committed legal value.
- ERROR  output  1  sticky; a stable non-digit pattern was seen.
- FRAME_DONE  output  1  one-cycle pulse; the last digit committed and all VALID bits are 1.

## Operation

- ABCDEFG and DIGIT_EN pass through a two-flop synchronizer; all decisions below use the synchronized values.
- Legal patterns (hex, a..g):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33
  - 5=5B, 6=5F, 7=70, 8=7F, 9=7B
- Any other pattern is illegal.
- Tracker FSM (one instance, shared across digits):
  - IDLE: DIGIT_EN is zero or multi-hot. Count is 0; nothing commits; no error is raised.
  - SETTLE: one-hot enable present.
    - Count increments, saturating at STABLE_CNT, while the enable and the pattern both match the previous sample.
    - Any change in either restarts the count at 1.
    - When count reaches STABLE_CNT, go to LOCKED and perform the commit.
  - LOCKED: no further commits. Any change in enable or pattern goes to SETTLE (count=1) or to IDLE.
- Commit to digit k:
  - Legal pattern: BCD[k] gets the digit value and VALID[k] is set to 1.
  - Illegal pattern: VALID[k] is set to 0 and ERROR is set to 1; BCD[k] holds its old value.
- FRAME_DONE pulses on the edge where digit DIGITS-1 commits legally, provided all other VALID bits are already 1.
- CLEAR sets VALID and ERROR to 0. A commit in the same cycle as CLEAR takes priority for its own digit, and for ERROR.
- Count register width is $clog2(STABLE_CNT+1).

## Timing

- Reset values:
  - BCD=0, VALID=0, ERROR=0, FRAME_DONE=0.
  - FSM=IDLE, count=0, synchronizer flops=0.
- Latency: from the first clk edge at which new inputs are present and then held stable, BCD and VALID update after exactly 2+STABLE_CNT edges.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-SETTLE discards the partial count. After release, a full 2+STABLE_CNT is needed before any commit.
- A digit enable shorter than STABLE_CNT synchronized cycles never commits.

## Configuration

- SEVEN_SEG_READER_BLANK_EN defined:
  - Pattern 00 (all segments off) is legal as "blank".
  - Commits BCD[k]=4'hF with VALID[k]=1.
  - Does not raise ERROR.
  - Counts toward FRAME_DONE.
- Not defined: pattern 00 is illegal, with the same handling as any other illegal pattern.

## Structure

- Package seven_seg_pkg holds:
  - segment pattern constants SEG_0…SEG_9 and SEG_BLANK;
  - BCD_BLANK (4'hF);
  - the tracker FSM state enum.
- Sub-module seven_seg_pattern_decoder: combinational, 7-bit pattern in; 4-bit digit plus legal flag out. The macro is honoured here.

## Test plan

- Reset, then DIGIT_EN=0001 with ABCDEFG=6D held (STABLE_CNT=3) -> BCD[3:0]=2 and VALID=0001 after exactly 5 edges; ERROR=0.
- Scan 4 digits showing 30,79,33,5B, each enabled 8 cycles -> BCD=16'h5431, VALID=1111; FRAME_DONE pulses once per frame on each commit of digit 3.
- Pattern toggling 7E/7F every cycle on digit 0 -> no commit, VALID unchanged.
- Stable illegal pattern 01 on digit 2 -> VALID[2]=0, ERROR=1. CLEAR pulse -> ERROR=0, VALID=0000.
- DIGIT_EN=0011 held stable (multi-hot) -> FSM IDLE, no commit, no error.
- Pattern 00 stable on digit 1: with SEVEN_SEG_READER_BLANK_EN -> BCD[7:4]=F and VALID[1]=1; without -> ERROR=1.
